// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU memory stage vs. debug/loader port, single-port RAM.
// Optional starvation guard for the debug port: define DMEM_ARB_STARVE_GUARD_EN.
module dmem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned READ_LAT   = 1,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;   // 1 = debug owns the outstanding read
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              dbg_rvalid_q, dbg_rvalid_d;

  logic              cpu_eligible;
  logic              dbg_force;
  logic              cpu_win;
  logic              dbg_win;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam int unsigned ST_W = $clog2(STARVE_MAX + 1);

  logic [ST_W-1:0] starve_q, starve_d;

  assign dbg_force = dbg_req && (starve_q == ST_W'(STARVE_MAX));

  always_comb begin
    starve_d = starve_q;
    if (!dbg_req || dbg_gnt) begin
      starve_d = '0;
    end else if (cpu_win && (starve_q < ST_W'(STARVE_MAX))) begin
      starve_d = starve_q + ST_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign dbg_force = 1'b0;
`endif

  // A request still held while its rvalid is showing has already been served.
  assign cpu_eligible = cpu_req && !cpu_rvalid_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    cpu_rvalid_d = 1'b0;
    dbg_rvalid_d = 1'b0;
    cpu_win      = 1'b0;
    dbg_win      = 1'b0;
    cpu_stall    = 1'b0;
    dbg_gnt      = 1'b0;
    mem_en       = 1'b0;
    mem_we       = '0;
    mem_addr     = '0;
    mem_wdata    = '0;

    case (state_q)
      IDLE: begin
        cpu_win = cpu_eligible && !dbg_force;
        dbg_win = dbg_req && !cpu_win;
        if (cpu_win) begin
          mem_en    = 1'b1;
          mem_we    = {4{cpu_we}};
          mem_addr  = cpu_addr;
          mem_wdata = cpu_wdata;
          if (!cpu_we) begin
            state_d   = RD_WAIT;
            owner_d   = 1'b0;
            cnt_d     = 2'(READ_LAT);
            cpu_stall = 1'b1;
          end
        end else if (dbg_win) begin
          mem_en    = 1'b1;
          mem_we    = {4{dbg_we}};
          mem_addr  = dbg_addr;
          mem_wdata = dbg_wdata;
          dbg_gnt   = 1'b1;
          cpu_stall = cpu_eligible;
          if (!dbg_we) begin
            state_d = RD_WAIT;
            owner_d = 1'b1;
            cnt_d   = 2'(READ_LAT);
          end
        end
      end
      RD_WAIT: begin
        cnt_d     = cnt_q - 2'd1;
        cpu_stall = owner_q ? cpu_req : 1'b1;
        if (cnt_q == 2'd1) begin
          state_d = IDLE;
          if (owner_q) begin
            dbg_rdata_d  = mem_rdata;
            dbg_rvalid_d = 1'b1;
          end else begin
            cpu_rdata_d  = mem_rdata;
            cpu_rvalid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Nothing is issued or stalled while reset is being applied.
    if (reset) begin
      cpu_stall = 1'b0;
      dbg_gnt   = 1'b0;
      mem_en    = 1'b0;
      mem_we    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
    end
  end

  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign dbg_rvalid = dbg_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: read responses checked through a scoreboard queue,
// issue-cycle signals checked directly. Starvation expectations follow DMEM_ARB_STARVE_GUARD_EN.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_rvalid, cpu_stall;
  logic        dbg_req, dbg_we;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        dbg_gnt, dbg_rvalid;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  typedef struct {
    bit          is_dbg;
    logic [31:0] data;
  } resp_t;

  resp_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  logic [31:0] mem [logic [31:0]];

  dmem_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .READ_LAT  (1),
    .STARVE_MAX(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_rvalid(cpu_rvalid),
    .cpu_stall (cpu_stall),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_gnt   (dbg_gnt),
    .dbg_rdata (dbg_rdata),
    .dbg_rvalid(dbg_rvalid),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM, one cycle read latency.
  always @(posedge clk) begin
    if (mem_en && (mem_we != 4'h0)) mem[mem_addr] = mem_wdata;
    if (mem_en && (mem_we == 4'h0)) mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit is_dbg, input logic [31:0] data);
    resp_t r;
    r.is_dbg = is_dbg;
    r.data   = data;
    exp_q.push_back(r);
  endtask

  // Monitor: every rvalid pulse must match the oldest outstanding expected read.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (cpu_rvalid || dbg_rvalid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rvalid: cpu_rvalid=%0b dbg_rvalid=%0b with no read outstanding at %0t",
                   cpu_rvalid, dbg_rvalid, $time);
        end else begin
          r = exp_q.pop_front();
          chk("rvalid_owner", {30'h0, cpu_rvalid, dbg_rvalid}, r.is_dbg ? 32'h1 : 32'h2);
          chk("rdata", r.is_dbg ? dbg_rdata : cpu_rdata, r.data);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    mem_rdata = '0;

    // Reset state
    repeat (2) next_cycle();
    @(negedge clk);
    chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
    chk("rst_stall", {31'h0, cpu_stall}, 32'h0);
    chk("rst_gnt", {31'h0, dbg_gnt}, 32'h0);
    chk("rst_rvalid", {30'h0, cpu_rvalid, dbg_rvalid}, 32'h0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_dbg_rdata", dbg_rdata, 32'h0);

    // CPU write
    next_cycle();
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h34; cpu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("wr_mem_en", {31'h0, mem_en}, 32'h1);
    chk("wr_mem_we", {28'h0, mem_we}, 32'hF);
    chk("wr_mem_addr", mem_addr, 32'h34);
    chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("wr_stall", {31'h0, cpu_stall}, 32'h0);

    // CPU read, held request
    next_cycle();
    cpu_we = 1'b0;
    push(1'b0, 32'hDEADBEEF);
    @(negedge clk);
    chk("rd_issue_en", {31'h0, mem_en}, 32'h1);
    chk("rd_issue_we", {28'h0, mem_we}, 32'h0);
    chk("rd_issue_stall", {31'h0, cpu_stall}, 32'h1);
    next_cycle();
    @(negedge clk);
    chk("rd_wait_en", {31'h0, mem_en}, 32'h0);
    chk("rd_wait_stall", {31'h0, cpu_stall}, 32'h1);
    next_cycle();
    @(negedge clk);
    chk("rd_done_stall", {31'h0, cpu_stall}, 32'h0);
    chk("rd_done_valid", {31'h0, cpu_rvalid}, 32'h1);
    chk("rd_done_no_reissue", {31'h0, mem_en}, 32'h0);
    next_cycle();
    cpu_req = 1'b0;

    // Debug write to 0x10
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h10; dbg_wdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("dwr_gnt", {31'h0, dbg_gnt}, 32'h1);
    chk("dwr_mem_we", {28'h0, mem_we}, 32'hF);
    chk("dwr_mem_addr", mem_addr, 32'h10);

    // Debug read, CPU arrives during the wait cycle
    next_cycle();
    dbg_we = 1'b0;
    push(1'b1, 32'hCAFEF00D);
    @(negedge clk);
    chk("drd_gnt", {31'h0, dbg_gnt}, 32'h1);
    chk("drd_en", {31'h0, mem_en}, 32'h1);
    chk("drd_stall", {31'h0, cpu_stall}, 32'h0);
    next_cycle();
    dbg_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h34;
    @(negedge clk);
    chk("drd_wait_stall", {31'h0, cpu_stall}, 32'h1);
    chk("drd_wait_en", {31'h0, mem_en}, 32'h0);
    next_cycle();
    push(1'b0, 32'hDEADBEEF);
    @(negedge clk);
    chk("cpu_after_dbg_en", {31'h0, mem_en}, 32'h1);
    chk("cpu_after_dbg_addr", mem_addr, 32'h34);
    chk("cpu_after_dbg_stall", {31'h0, cpu_stall}, 32'h1);
    next_cycle();
    @(negedge clk);
    chk("cpu_after_dbg_wait", {31'h0, cpu_stall}, 32'h1);
    next_cycle();
    @(negedge clk);
    chk("cpu_after_dbg_done", {31'h0, cpu_stall}, 32'h0);
    next_cycle();
    cpu_req = 1'b0;
    next_cycle();

    // Starvation: CPU writes every cycle while debug waits
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h0;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h20; dbg_wdata = 32'h5A5A5A5A;
    for (int i = 0; i < 12; i++) begin
      cpu_wdata = 32'(i);
      @(negedge clk);
`ifdef DMEM_ARB_STARVE_GUARD_EN
      if (i < 8) begin
        chk("starve_cpu_gnt", {31'h0, dbg_gnt}, 32'h0);
        chk("starve_cpu_addr", mem_addr, 32'h40);
        chk("starve_cpu_stall", {31'h0, cpu_stall}, 32'h0);
      end else if (i == 8) begin
        chk("starve_dbg_gnt", {31'h0, dbg_gnt}, 32'h1);
        chk("starve_dbg_addr", mem_addr, 32'h20);
        chk("starve_dbg_stall", {31'h0, cpu_stall}, 32'h1);
      end else begin
        chk("starve_after_gnt", {31'h0, dbg_gnt}, 32'h0);
        chk("starve_after_addr", mem_addr, 32'h40);
      end
      next_cycle();
      if (i == 8) dbg_req = 1'b0;
`else
      chk("strict_no_gnt", {31'h0, dbg_gnt}, 32'h0);
      chk("strict_cpu_addr", mem_addr, 32'h40);
      chk("strict_stall", {31'h0, cpu_stall}, 32'h0);
      next_cycle();
`endif
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    next_cycle();

    // Reset during the wait cycle of a CPU read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h34;
    @(negedge clk);
    chk("abort_issue_stall", {31'h0, cpu_stall}, 32'h1);
    next_cycle();
    cpu_req = 1'b0;
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_rvalid", {31'h0, cpu_rvalid}, 32'h0);
    chk("abort_rdata", cpu_rdata, 32'h0);
    chk("abort_stall", {31'h0, cpu_stall}, 32'h0);
    chk("abort_mem_en", {31'h0, mem_en}, 32'h0);
    next_cycle();

    // Normal read after the abort
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    push(1'b0, 32'hCAFEF00D);
    @(negedge clk);
    chk("post_rst_issue", {31'h0, mem_en}, 32'h1);
    repeat (2) next_cycle();
    @(negedge clk);
    chk("post_rst_stall", {31'h0, cpu_stall}, 32'h0);
    next_cycle();
    cpu_req = 1'b0;
    repeat (3) next_cycle();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
